// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks.
//   SEG_OFF / AN_OFF : all-dark patterns for active-low segments and anodes
//   HEX_GLYPH        : active-low glyph per hex nibble, bit 0 = segment a
//   snap_t           : per-frame snapshot of the display inputs
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned VAL_W = 16;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;
  localparam logic [AN_W-1:0]  AN_OFF  = 4'b1111;

  // Entry n is the glyph for nibble n (listed F down to 0).
  localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic [AN_W-1:0]  blank;
    logic             lzs;
  } snap_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
//   i_nibble : hex digit 0..F
//   o_seg_c  : active-low segments, [0]=a .. [6]=g
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment bank.
//   clk, rst   : clock, synchronous active-high reset
//   value      : four hex digits, [3:0] = rightmost digit 0
//   blank      : bit k forces digit k dark
//   lzs        : suppress leading zeros (digit 0 always shown)
//   seg, an    : registered active-low segments / anodes
//   frame_tick : one-cycle pulse when a new input snapshot is taken
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  input  logic [AN_W-1:0]  blank,
  input  logic             lzs,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             frame_tick
);

  localparam int unsigned      CNT_W    = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  snap_t            r_snap;
  logic             r_live;

  logic             w_wrap;
  logic             w_guard;
  logic             w_dark;
  logic [NIB_W-1:0] w_nibble;
  logic [SEG_W-1:0] w_glyph;
  logic [AN_W-1:0]  w_lead_zero;
  logic [SEG_W-1:0] w_seg_nxt;
  logic [AN_W-1:0]  w_an_nxt;

  assign w_wrap = (r_cnt == CNT_LAST);

  // Guard window at the start of every dwell; absent entirely when zero.
  if (GUARD_CYCLES == 0) begin : g_no_guard
    assign w_guard = 1'b0;
  end else begin : g_guard
    assign w_guard = (r_cnt < CNT_W'(GUARD_CYCLES));
  end

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
  always_comb begin
    w_lead_zero    = '0;
    w_lead_zero[3] = (r_snap.value[15:12] == 4'h0);
    w_lead_zero[2] = w_lead_zero[3] && (r_snap.value[11:8] == 4'h0);
    w_lead_zero[1] = w_lead_zero[2] && (r_snap.value[7:4] == 4'h0);
  end

  // Nibble of the currently scanned digit.
  always_comb begin
    w_nibble = r_snap.value[3:0];
    case (r_idx)
      2'd0:    w_nibble = r_snap.value[3:0];
      2'd1:    w_nibble = r_snap.value[7:4];
      2'd2:    w_nibble = r_snap.value[11:8];
      default: w_nibble = r_snap.value[15:12];
    endcase
  end

  assign w_dark = r_snap.blank[r_idx] | (r_snap.lzs & w_lead_zero[r_idx]);

  hex_to_seg7 u_hex (
    .i_nibble (w_nibble),
    .o_seg_c  (w_glyph)
  );

  // Next-cycle output pattern; at most one anode is ever driven low.
  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if (r_live && !w_guard && !w_dark) begin
      w_an_nxt  = ~(AN_W'(1) << r_idx);
      w_seg_nxt = w_glyph;
    end
  end

  // Scan counter, frame snapshot and registered outputs. r_live masks the one
  // output cycle that would otherwise decode the reset-state counter/index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= CNT_LAST;
      r_idx      <= IDX_W'(3);
      r_snap     <= '0;
      r_live     <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
    end else begin
      r_live     <= 1'b1;
      frame_tick <= 1'b0;
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(3)) begin
          r_snap     <= '{value: value, blank: blank, lzs: lzs};
          frame_tick <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      seg <= w_seg_nxt;
      an  <= w_an_nxt;
    end
  end

endmodule
